// File: rtl/evt_pkt_writer.sv
// Event packet writer: frames pairs of event words taken from an event FIFO into
// packets of one header word followed by up to MAX_PKT_WORDS payload words.
module evt_pkt_writer #(
  parameter int                    DATA_WIDTH     = 64,
  parameter int                    CTRL_WIDTH     = DATA_WIDTH / 8,
  parameter int                    NUM_WORDS_BITS = 6,
  parameter int                    MAX_PKT_WORDS  = 8,
  parameter int                    TIMEOUT        = 1000,
  parameter logic [CTRL_WIDTH-1:0] HDR_CTRL       = CTRL_WIDTH'(8'hFF),
  parameter logic [CTRL_WIDTH-1:0] LAST_CTRL      = CTRL_WIDTH'(8'h01)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     fifo_dout,
  input  logic                      fifo_empty,
  input  logic [NUM_WORDS_BITS-1:0] fifo_num_words,
  output logic                      fifo_rd_en,
  input  logic                      flush,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [CTRL_WIDTH-1:0]     out_ctrl,
  output logic                      out_wr,
  input  logic                      out_rdy,
  output logic [31:0]               pkt_seq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD
  } state_t;

  localparam logic [NUM_WORDS_BITS-1:0] MAX_WORDS   = NUM_WORDS_BITS'(MAX_PKT_WORDS);
  localparam logic [15:0]               TIMEOUT_CNT = 16'(TIMEOUT);

  state_t                    r_state;
  logic [15:0]               r_timer;
  logic [15:0]               r_len;
  logic [15:0]               r_remaining;
  logic [31:0]               r_pkt_seq;
  logic                      r_out_wr;
  logic [DATA_WIDTH-1:0]     r_out_data;
  logic [CTRL_WIDTH-1:0]     r_out_ctrl;

  logic [NUM_WORDS_BITS-1:0] w_avail;
  logic                      w_start;
  logic [15:0]               w_start_len;
  logic [63:0]               w_hdr64;
  logic [DATA_WIDTH-1:0]     w_hdr_word;
  logic                      w_last;
  logic                      w_rd_en;

  // Payload words available; an odd trailing event word waits for its partner.
  assign w_avail     = fifo_num_words >> 1;

  assign w_start     = (r_state == S_IDLE) &&
                       ((w_avail >= MAX_WORDS) ||
                        ((w_avail != '0) && ((r_timer == TIMEOUT_CNT) || flush)));
  assign w_start_len = (w_avail >= MAX_WORDS) ? 16'(MAX_WORDS) : 16'(w_avail);

  assign w_hdr64     = {16'h0, r_len, r_pkt_seq};
  assign w_hdr_word  = DATA_WIDTH'(w_hdr64);
  assign w_last      = (r_remaining == 16'd1);

  // The read strobe is combinational so the FIFO pops in the same cycle the
  // word is captured into the output register.
  assign w_rd_en     = (r_state == S_PAYLOAD) && out_rdy && !fifo_empty;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_len       <= '0;
      r_remaining <= '0;
      r_pkt_seq   <= '0;
      r_out_wr    <= 1'b0;
      r_out_data  <= '0;
      r_out_ctrl  <= '0;
    end else begin
      r_out_wr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_len   <= w_start_len;
            r_timer <= '0;
            r_state <= S_HEADER;
          end else if (w_avail == '0) begin
            r_timer <= '0;
          end else if (r_timer != TIMEOUT_CNT) begin
            r_timer <= r_timer + 16'd1;
          end
        end

        S_HEADER: begin
          if (out_rdy) begin
            r_out_wr    <= 1'b1;
            r_out_ctrl  <= HDR_CTRL;
            r_out_data  <= w_hdr_word;
            r_remaining <= r_len;
            r_state     <= S_PAYLOAD;
          end
        end

        S_PAYLOAD: begin
          if (w_rd_en) begin
            r_out_wr    <= 1'b1;
            r_out_data  <= fifo_dout;
            r_out_ctrl  <= w_last ? LAST_CTRL : '0;
            r_remaining <= r_remaining - 16'd1;
            if (w_last) begin
              r_pkt_seq <= r_pkt_seq + 32'd1;
              r_state   <= S_IDLE;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign fifo_rd_en = w_rd_en;
  assign out_wr     = r_out_wr;
  assign out_data   = r_out_data;
  assign out_ctrl   = r_out_ctrl;
  assign pkt_seq    = r_pkt_seq;

endmodule

// File: tb/tb_evt_pkt_writer.sv
// Self-checking bench for evt_pkt_writer: a small event FIFO model feeds the DUT and
// expected packets are derived from the event words and packet-length arithmetic.
module tb_evt_pkt_writer;

  localparam int DW   = 64;
  localparam int CW   = 8;
  localparam int NWB  = 6;
  localparam int MAXW = 8;
  localparam int TMO  = 20;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [DW-1:0]   fifo_dout;
  logic            fifo_empty;
  logic [NWB-1:0]  fifo_num_words;
  logic            fifo_rd_en;
  logic            flush;
  logic [DW-1:0]   out_data;
  logic [CW-1:0]   out_ctrl;
  logic            out_wr;
  logic            out_rdy;
  logic [31:0]     pkt_seq;

  evt_pkt_writer #(
    .DATA_WIDTH    (DW),
    .CTRL_WIDTH    (CW),
    .NUM_WORDS_BITS(NWB),
    .MAX_PKT_WORDS (MAXW),
    .TIMEOUT       (TMO),
    .HDR_CTRL      (8'hFF),
    .LAST_CTRL     (8'h01)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_dout     (fifo_dout),
    .fifo_empty    (fifo_empty),
    .fifo_num_words(fifo_num_words),
    .fifo_rd_en    (fifo_rd_en),
    .flush         (flush),
    .out_data      (out_data),
    .out_ctrl      (out_ctrl),
    .out_wr        (out_wr),
    .out_rdy       (out_rdy),
    .pkt_seq       (pkt_seq)
  );

  always #5 clk = ~clk;

  // Event FIFO environment: ev[] holds every event word ever pushed.
  logic [31:0] ev [0:4095];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic        fifo_clr;

  assign fifo_num_words = NWB'(wr_ptr - rd_ptr);
  assign fifo_empty     = (wr_ptr - rd_ptr) < 2;
  assign fifo_dout      = {ev[12'(rd_ptr + 1)], ev[12'(rd_ptr)]};

  always @(posedge clk) begin
    if (fifo_clr) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en) begin
      rd_ptr <= rd_ptr + 2;
      rd_cnt <= rd_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (out_wr) wr_cnt <= wr_cnt + 1;
  end

  // Reference model state
  int          cons    = 0;
  logic [31:0] exp_seq = 32'h0;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      ev[12'(wr_ptr)] = $urandom;
      wr_ptr++;
    end
  endtask

  task automatic clear_fifo();
    fifo_clr = 1'b1;
    @(negedge clk);
    fifo_clr = 1'b0;
    cons     = wr_ptr;
  endtask

  // Collects stop_words output words (header first) and checks them against the model.
  // rdy_mode: 0 = out_rdy held high, 1 = toggled each cycle, 2 = random.
  task automatic expect_packet(input int len, input int rdy_mode, input int stop_words,
                               output int hdr_cyc);
    int          got;
    int          cyc;
    logic [63:0] exp_d;
    logic [63:0] exp_c;
    got     = 0;
    cyc     = 0;
    hdr_cyc = -1;
    while (got < stop_words && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (out_wr) begin
        if (got == 0) begin
          exp_d   = {16'h0, 16'(len), exp_seq};
          exp_c   = 64'hFF;
          hdr_cyc = cyc;
        end else begin
          exp_d = {ev[12'(cons + 1)], ev[12'(cons)]};
          cons += 2;
          exp_c = (got == len) ? 64'h01 : 64'h00;
        end
        check($sformatf("seq%0h_word%0d_data", exp_seq, got), out_data, exp_d);
        check($sformatf("seq%0h_word%0d_ctrl", exp_seq, got), 64'(out_ctrl), exp_c);
        got++;
      end
      case (rdy_mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = !out_rdy;
        default: out_rdy = 1'($urandom_range(0, 1));
      endcase
    end
    check($sformatf("seq%0h_words_seen", exp_seq), 64'(got), 64'(stop_words));
    if (stop_words == len + 1) exp_seq++;
  endtask

  initial begin
    int hc;
    int rd0;
    int wr0;
    int n;
    int avail;
    int l;

    rst_n    = 1'b0;
    out_rdy  = 1'b1;
    flush    = 1'b0;
    fifo_clr = 1'b0;

    // Reset state
    #2;
    check("rst_out_wr",   64'(out_wr),     64'h0);
    check("rst_out_data", out_data,        64'h0);
    check("rst_out_ctrl", 64'(out_ctrl),   64'h0);
    check("rst_pkt_seq",  64'(pkt_seq),    64'h0);
    check("rst_rd_en",    64'(fifo_rd_en), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Full packet from 16 event words
    rd0 = rd_cnt;
    push(16);
    expect_packet(8, 0, 9, hc);
    @(negedge clk);
    check("full_pkt_seq",   64'(pkt_seq),        64'(exp_seq));
    check("full_fifo_left", 64'(fifo_num_words), 64'h0);
    check("full_rd_count",  64'(rd_cnt - rd0),   64'd8);

    // out_rdy toggling every cycle
    rd0     = rd_cnt;
    wr0     = wr_cnt;
    out_rdy = 1'b0;
    push(16);
    expect_packet(8, 1, 9, hc);
    out_rdy = 1'b1;
    repeat (6) @(negedge clk);
    check("toggle_wr_count", 64'(wr_cnt - wr0), 64'd9);
    check("toggle_rd_count", 64'(rd_cnt - rd0), 64'd8);
    check("toggle_pkt_seq",  64'(pkt_seq),      64'(exp_seq));

    // Flush pulse with 3 event words: no timeout wait
    push(3);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_no_early_wr", 64'(out_wr), 64'h0);
    expect_packet(1, 0, 2, hc);
    check("flush_hdr_latency", 64'(hc + 1), 64'd2);
    @(negedge clk);
    check("flush_fifo_left", 64'(fifo_num_words), 64'd1);
    clear_fifo();

    // Timeout with 5 event words
    push(5);
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      check($sformatf("tmo_quiet_%0d", i), 64'(out_wr), 64'h0);
    end
    expect_packet(2, 0, 3, hc);
    check("tmo_hdr_cycle",  64'(hc),             64'd2);
    check("tmo_fifo_left",  64'(fifo_num_words), 64'd1);
    check("tmo_pkt_seq",    64'(pkt_seq),        64'(exp_seq));
    clear_fifo();

    // Randomized rounds: flush held, random out_rdy, random event counts
    for (int r = 0; r < 6; r++) begin
      n     = int'($urandom_range(2, 40));
      avail = n / 2;
      push(n);
      flush = 1'b1;
      while (avail > 0) begin
        l = (avail < MAXW) ? avail : MAXW;
        expect_packet(l, 2, l + 1, hc);
        avail -= l;
      end
      flush   = 1'b0;
      out_rdy = 1'b1;
      @(negedge clk);
      check($sformatf("rand%0d_fifo_left", r), 64'(fifo_num_words), 64'(n % 2));
      check($sformatf("rand%0d_pkt_seq", r),   64'(pkt_seq),        64'(exp_seq));
      clear_fifo();
    end

    // Sequence number wrap
    @(negedge clk);
    force dut.r_pkt_seq = 32'hFFFF_FFFF;
    #1;
    release dut.r_pkt_seq;
    exp_seq = 32'hFFFF_FFFF;
    check("wrap_preload", 64'(pkt_seq), 64'hFFFF_FFFF);
    @(negedge clk);
    push(16);
    expect_packet(8, 0, 9, hc);
    check("wrap_seq_zero", 64'(pkt_seq), 64'h0);
    push(16);
    expect_packet(8, 0, 9, hc);
    check("wrap_seq_one", 64'(pkt_seq), 64'h1);

    // Reset after the 3rd payload word
    push(16);
    expect_packet(8, 0, 4, hc);
    rst_n = 1'b0;
    #1;
    check("midrst_out_wr",   64'(out_wr),     64'h0);
    check("midrst_pkt_seq",  64'(pkt_seq),    64'h0);
    check("midrst_out_data", out_data,        64'h0);
    check("midrst_rd_en",    64'(fifo_rd_en), 64'h0);
    exp_seq = 32'h0;
    clear_fifo();
    rst_n = 1'b1;
    wr0   = wr_cnt;
    repeat (5) @(negedge clk);
    check("midrst_quiet", 64'(wr_cnt - wr0), 64'h0);
    push(16);
    expect_packet(8, 0, 9, hc);
    @(negedge clk);
    check("midrst_fresh_seq", 64'(pkt_seq), 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/evt_pkt_writer.md
EVT_PKT_WRITER -- requirements
Module: evt_pkt_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, payload word width; equals the event FIFO output word width (2 event words).
REQ-002 SHALL have parameter CTRL_WIDTH, default DATA_WIDTH/8, control bus width.
REQ-003 SHALL have parameter NUM_WORDS_BITS, default 6, width of the FIFO occupancy input, counted in event (half-payload) words.
REQ-004 SHALL have parameter MAX_PKT_WORDS, default 8, maximum payload words per packet, range 1..2**(NUM_WORDS_BITS-1).
REQ-005 SHALL have parameter TIMEOUT, default 1000, idle cycles before a partial packet is sent, range 1..65535.
REQ-006 SHALL have parameter HDR_CTRL, default 8'hFF, ctrl value of the header word.
REQ-007 SHALL have parameter LAST_CTRL, default 8'h01, ctrl value of the last payload word.
REQ-008 clk  input  1  single clock; all state changes on rising edge.
REQ-009 rst_n  input  1  asynchronous, active-low reset.
REQ-010 fifo_dout  input  DATA_WIDTH  event FIFO head word, valid whenever fifo_empty is low.
REQ-011 fifo_empty  input  1  event FIFO holds fewer than 2 event words.
REQ-012 fifo_num_words  input  NUM_WORDS_BITS  event FIFO occupancy in event words.
REQ-013 fifo_rd_en  output  1  pops one payload word (2 event words) from the event FIFO.
REQ-014 flush  input  1  level; sends pending words without waiting for timeout.
REQ-015 out_data  output  DATA_WIDTH  packet word.
REQ-016 out_ctrl  output  CTRL_WIDTH  packet word control.
REQ-017 out_wr  output  1  out_data/out_ctrl valid this cycle.
REQ-018 out_rdy  input  1  downstream can accept a word next cycle.
REQ-019 pkt_seq  output  32  sequence number of the next packet to be sent.

Function
REQ-020 SHALL implement states IDLE, HEADER, PAYLOAD.
REQ-021 avail = fifo_num_words>>1 (floor; an odd leftover event word remains in the FIFO).
REQ-022 In IDLE, SHALL start a packet when avail>=MAX_PKT_WORDS, or avail>=1 and (timer==TIMEOUT or flush==1); on start, latch len=min(avail,MAX_PKT_WORDS), zero timer, go to HEADER.
REQ-023 Timer (16-bit) SHALL increment each IDLE cycle with avail>=1 and no start, saturate at TIMEOUT, and clear when avail==0 or on start.
REQ-024 In HEADER with out_rdy=1: register out_wr=1, out_ctrl=HDR_CTRL, out_data={16'h0, len[15:0], pkt_seq}; go to PAYLOAD. With out_rdy=0: hold, out_wr=0.
REQ-025 fifo_rd_en SHALL be combinational: state==PAYLOAD & out_rdy & !fifo_empty.
REQ-026 On each fifo_rd_en cycle: register out_wr=1, out_data=fifo_dout, out_ctrl=LAST_CTRL if this is word len else 0; decrement remaining count.
REQ-027 After word len is written: increment pkt_seq (mod 2**32 wrap), return to IDLE; next start SHALL NOT occur in the same cycle.
REQ-028 out_wr SHALL be 0 in any cycle without a HEADER or fifo_rd_en transfer in the previous cycle; out_data/out_ctrl hold when out_wr=0.
REQ-029 Latency: header appears on out_* one cycle after start-cycle+1 (HEADER cycle with out_rdy); payload word one cycle after its fifo_rd_en.
REQ-030 out_rdy low mid-packet SHALL stall without loss or duplication; fifo_empty high in PAYLOAD SHALL stall (no read, no out_wr).
REQ-031 flush asserted during HEADER/PAYLOAD SHALL have no effect on the current packet.

Reset
REQ-032 rst_n low SHALL asynchronously force state=IDLE, timer=0, len=0, out_wr=0, out_data=0, out_ctrl=0, pkt_seq=0; fifo_rd_en=0 follows.
REQ-033 Reset mid-packet SHALL abandon the packet; no further words emitted after deassertion until a new start.

Verification
REQ-034 16 event words present, out_rdy=1 -> header {len=8, seq=0}, ctrl FF, then 8 payload words in order, 8th ctrl 01, pkt_seq=1.
REQ-035 5 event words, no flush, TIMEOUT=20 -> nothing for 20 idle cycles, then packet len=2; 1 event word left, fifo_num_words=1.
REQ-036 3 event words, flush=1 pulse -> packet len=1 within 3 cycles; no timeout wait.
REQ-037 out_rdy toggled 0/1 every cycle during 8-word packet -> all 9 words delivered, no duplicates, fifo_rd_en count=8.
REQ-038 rst_n low after 3rd payload word -> out_wr=0 immediately, pkt_seq=0; after release with 16 event words, fresh packet len=8 seq=0.
REQ-039 pkt_seq preloaded via 2**32 packets (or forced 32'hFFFFFFFF) -> header carries FFFFFFFF, next packet header carries 0.
